// File: rtl/vfu_pkg.sv
// Shared definitions for the VFU result path: lane word width and the
// flat-bus lane slicing helper.
package vfu_pkg;

    localparam int FP16_W = 16;

    // Lane i of a flat N-lane bus occupies [lane_lsb(i) +: FP16_W].
    function automatic int lane_lsb(input int lane);
        return lane * FP16_W;
    endfunction

endpackage

// File: rtl/vfu_gather_lane.sv
// One lane of the result gather buffer: its own write pointer, DEPTH words,
// per-row filled bits, and the overflow detect for this lane.
module vfu_gather_lane
    import vfu_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    input  logic [FP16_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_ptr,
    input  logic              pop,
    output logic [FP16_W-1:0] rd_data,
    output logic              head_filled,
    output logic              overflow
);

    logic [AW-1:0]     wr_ptr;
    logic [FP16_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  filled;
    logic              target_busy;
    logic              accept;

    // A pop of the very row this lane targets frees it in the same edge.
    always_comb begin
        target_busy = filled[wr_ptr] && !(pop && (rd_ptr == wr_ptr));
        accept      = wr_valid && !target_busy;
    end

    assign overflow    = wr_valid && target_busy;
    assign rd_data     = mem[rd_ptr];
    assign head_filled = filled[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            filled <= '0;
            for (int r = 0; r < DEPTH; r++) begin
                mem[r] <= '0;
            end
        end else begin
            if (pop) begin
                filled[rd_ptr] <= 1'b0;
            end
            if (accept) begin
                filled[wr_ptr] <= 1'b1;
                mem[wr_ptr]    <= wr_data;
                wr_ptr         <= wr_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/vfu_result_gather.sv
// Reassembles per-lane VFU results into in-order N-lane vectors on a
// valid/ready stream and hands out issue credits to protect the buffer.
module vfu_result_gather
    import vfu_pkg::*;
#(
    parameter int N     = 4,
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_tvalid,
    output logic                  issue_tready,
    input  logic [N-1:0]          lane_tvalid,
    input  logic [N*FP16_W-1:0]   lane_data_flat,
    output logic                  out_tvalid,
    input  logic                  out_tready,
    output logic [N*FP16_W-1:0]   out_data_flat,
    output logic                  overflow_err
);

    localparam int            AW        = $clog2(DEPTH);
    localparam logic [AW:0]   DEPTH_CNT = (AW+1)'(DEPTH);

    logic [AW-1:0] rd_ptr;
    logic [AW:0]   credit_cnt;
    logic [N-1:0]  head_filled;
    logic [N-1:0]  lane_ovf;
    logic          pop;
    logic          issue_fire;

    for (genvar g = 0; g < N; g++) begin : g_lane
        vfu_gather_lane #(
            .DEPTH(DEPTH)
        ) u_lane (
            .clk        (clk),
            .rst        (rst),
            .wr_valid   (lane_tvalid[g]),
            .wr_data    (lane_data_flat[lane_lsb(g) +: FP16_W]),
            .rd_ptr     (rd_ptr),
            .pop        (pop),
            .rd_data    (out_data_flat[lane_lsb(g) +: FP16_W]),
            .head_filled(head_filled[g]),
            .overflow   (lane_ovf[g])
        );
    end

    assign out_tvalid   = &head_filled;
    assign pop          = out_tvalid && out_tready;
    assign issue_tready = (credit_cnt < DEPTH_CNT);
    assign issue_fire   = issue_tvalid && issue_tready;

    // Credits track rows issued but not yet popped; overflow is sticky.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr       <= '0;
            credit_cnt   <= '0;
            overflow_err <= 1'b0;
        end else begin
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (issue_fire && !pop) begin
                credit_cnt <= credit_cnt + 1'b1;
            end else if (!issue_fire && pop) begin
                credit_cnt <= credit_cnt - 1'b1;
            end
            if (|lane_ovf) begin
                overflow_err <= 1'b1;
            end
        end
    end

endmodule

// File: doc/vfu_result_gather.md
# vfu_result_gather

Downstream end of the VFU lane-result stream. Accepts per-lane FP16 results from an N-lane VFU arithmetic module, such as `add_module`. That interface carries `out_tvalid` only and has no ready, so every beat must be taken. Lanes may finish a vector in different cycles. The block reassembles complete N-lane vectors in order and presents each one on a valid/ready output stream. It also grants issue credits upstream so the arithmetic stage can never overrun the buffer.

## Interface
- `N`, 4: number of lanes.
- `DEPTH`, 4: vector rows buffered; power of two, ≥ 2.
- `clk`  in  1  sole clock; all state is updated on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `issue_tvalid`  in  1  upstream wants to issue one N-lane vector into the arithmetic stage.
- `issue_tready`  out  1  a credit is available; an issue fires when `issue_tvalid & issue_tready`.
- `lane_tvalid`  in  N  per-lane result strobe; connects to the arithmetic module's `out_tvalid`.
- `lane_data_flat`  in  N*16  per-lane FP16 result; lane i occupies bits [i*16 +: 16].
- `out_tvalid`  out  1  the head row holds all N lanes.
- `out_tready`  in  1  downstream accepts the head row.
- `out_data_flat`  out  N*16  head row; lane i at [i*16 +: 16].
- `overflow_err`  out  1  sticky; a lane wrote into a row that was still occupied.

## Operation
- Storage is a DEPTH × N array of 16-bit words plus a DEPTH × N `filled` bit matrix.
- Write pointers, one per lane:
  - Each lane has its own `wr_ptr[i]`, width clog2(DEPTH); it wraps modulo DEPTH.
  - When `lane_tvalid[i]` = 1 and `filled[wr_ptr[i]][i]` = 0, the block stores the data, sets the filled bit, and increments `wr_ptr[i]`.
- Overflow:
  - If `lane_tvalid[i]` = 1 and the target filled bit is already set, the beat is dropped.
  - Neither the pointer nor the data changes, and `overflow_err` is set until reset.
  - The exception is a pop of that same row in the same cycle. The pop clears the row first, so the write is accepted with no error.
- Read side:
  - A single `rd_ptr` addresses the head row.
  - `out_tvalid` = AND of all `filled[rd_ptr][*]`.
  - `out_data_flat` is driven combinationally from row `rd_ptr`.
  - A pop occurs when `out_tvalid & out_tready`. It clears all N filled bits of the row and increments `rd_ptr`.
- Credits:
  - `credit_cnt` has width clog2(DEPTH)+1 and counts rows that have been issued but not yet popped.
  - `issue_tready` = (`credit_cnt` < DEPTH).
  - The count increments on an issue fire and decrements on a pop. Both in the same cycle leaves it unchanged.
- Upstream that respects `issue_tready` can never trigger an overflow. `overflow_err` exists purely as a protocol checker.
- Data is stored bit-exact; the block does no FP16 interpretation.

## Timing
- Reset (`rst` = 0, asynchronous):
  - All `wr_ptr`, `rd_ptr`, `credit_cnt`, filled bits and `overflow_err` are cleared.
  - Outputs: `out_tvalid` = 0, `issue_tready` = 1, `overflow_err` = 0, `out_data_flat` = 0 (the storage array is reset as well).
- Asserting reset mid-operation discards every buffered and in-flight vector. Results that arrive after release are written from row 0.
- Latency: the last lane of a row written at edge k makes `out_tvalid` = 1 in the cycle after edge k. Minimum latency is therefore one cycle.
- `out_tvalid`, once high, stays high with stable data until the row is popped.
- Throughput: one row per cycle when `out_tready` = 1 and the lanes keep pace.
- Full buffer: `credit_cnt` = DEPTH forces `issue_tready` = 0. A pop at edge k makes `issue_tready` = 1 in the cycle after edge k.
- Empty: `out_tvalid` = 0; `out_tready` is ignored.
- Wrap-around: every pointer runs modulo DEPTH. Lanes may be up to DEPTH rows apart without corrupting data.

## Structure
- Shared package `vfu_pkg`:
  - `FP16_W` = 16.
  - A lane-slice helper function for the [i*16 +: 16] convention.
- Sub-module `vfu_gather_lane`, instantiated N times, holds one lane's:
  - `wr_ptr`;
  - DEPTH words and filled bits;
  - write and pop logic;
  - overflow detect.
- Top level: `rd_ptr`, the credit counter, the AND reduction and the output mux.

## Test plan
- Aligned lanes: issue 1 vector, then all lanes deliver 3E00/4100/4300/4480 (1.0+0.5, 2.0+0.5, 3.0+0.5, 4.0+0.5) in the same cycle, with `out_tready` = 1. One cycle later `out_data_flat` = 4480_4300_4100_3E00 with `out_tvalid` for exactly one cycle.
- Skewed lanes: the lanes deliver on cycles 0, 2, 5 and 1. `out_tvalid` stays 0 until the cycle after lane 2's beat, and the data is correct.
- Backpressure and credits: hold `out_tready` = 0 and issue 4 vectors. `issue_tready` drops after the 4th. Release `out_tready`: 4 in-order pops follow, and `issue_tready` returns one cycle after the first pop.
- Wrap and lane run-ahead: stream 10 vectors, with lane 0 three rows ahead of lane 3. All 10 vectors emerge in order, intact.
- Overflow: fill all 4 rows with `out_tready` = 0, then pulse `lane_tvalid[1]`. `overflow_err` = 1 and stays there; the head row is unchanged.
- Reset mid-stream: pull `rst` low while 2 rows are buffered. `out_tvalid`, `credit_cnt` and `overflow_err` go to 0 immediately and `issue_tready` goes to 1.
